// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered release of per-stage resets with ack handshake and timeout
module reset_sequencer #(
    parameter int N_STAGES    = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic [N_STAGES-1:0] stage_ack,
    output logic [N_STAGES-1:0] rst_out,
    output logic                busy,
    output logic                done,
    output logic                timeout_err
);

    localparam int MAX_HG  = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int MAX_CNT = (MAX_HG > ACK_TIMEOUT) ? MAX_HG : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int K_W     = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
    localparam logic [K_W-1:0]   K_LAST    = K_W'(N_STAGES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_WAIT_ACK,
        S_GAP,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [K_W-1:0]      k_q, k_d, k_nxt;
    logic [N_STAGES-1:0] rst_out_q, rst_out_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                terr_q, terr_d;
    logic                ack_k;
    logic                wait_over;

    // Bit i stays in reset only while i is above the stage currently being released.
    function automatic logic [N_STAGES-1:0] hold_mask(input logic [K_W-1:0] k);
        logic [N_STAGES-1:0] m;
        for (int i = 0; i < N_STAGES; i++) begin
            m[i] = (i > int'(k));
        end
        return m;
    endfunction

    always_comb begin
        ack_k = 1'b0;
        for (int i = 0; i < N_STAGES; i++) begin
            if (K_W'(i) == k_q) begin
                ack_k = stage_ack[i];
            end
        end
    end

    assign cnt_inc   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
    assign k_nxt     = k_q + K_W'(1);
    assign wait_over = ack_k || (cnt_q == ACK_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        rst_out_d = rst_out_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        terr_d    = terr_q;

        case (state_q)
            S_IDLE: begin
                rst_out_d = '0;
                busy_d    = 1'b0;
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d   = S_WAIT_ACK;
                    cnt_d     = '0;
                    k_d       = '0;
                    rst_out_d = hold_mask('0);
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WAIT_ACK: begin
                if (wait_over) begin
                    // A timeout advances exactly like an ack on the last wait cycle.
                    if (!ack_k) begin
                        terr_d = 1'b1;
                    end
                    cnt_d = '0;
                    if (k_q == K_LAST) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (STAGE_GAP == 0) begin
                        k_d       = k_nxt;
                        rst_out_d = hold_mask(k_nxt);
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d   = S_WAIT_ACK;
                    cnt_d     = '0;
                    k_d       = k_nxt;
                    rst_out_d = hold_mask(k_nxt);
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                rst_out_d = '0;
                busy_d    = 1'b0;
            end
            default: begin
                state_d   = S_HOLD;
                cnt_d     = '0;
                k_d       = '0;
                rst_out_d = '1;
                busy_d    = 1'b1;
            end
        endcase

        // A request in any state (re)starts the full sequence from HOLD.
        if (req) begin
            state_d   = S_HOLD;
            cnt_d     = '0;
            k_d       = '0;
            rst_out_d = '1;
            busy_d    = 1'b1;
            done_d    = 1'b0;
            terr_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_HOLD;
            cnt_q     <= '0;
            k_q       <= '0;
            rst_out_q <= '1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            rst_out_q <= rst_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            terr_q    <= terr_d;
        end
    end

    assign rst_out     = rst_out_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req = 1'b0;
    logic       rst1 = 1'b0;
    logic       req1 = 1'b0;
    logic [2:0] ack = 3'b000;
    logic [0:0] ack1 = 1'b0;
    logic [2:0] ro;
    logic       busy, done, terr;
    logic [0:0] ro1;
    logic       busy1, done1, terr1;

    typedef struct {
        int         cyc;
        logic [2:0] ro;
        logic       busy;
        logic       done;
        logic       terr;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];
    ev_t a0, a1, prev0, prev1;
    int  cyc = 0;
    int  base = 0;
    int  checks = 0;
    int  failures = 0;
    int  mode[3];
    int  mode1 = 0;
    int  d[3];
    int  d1 = 0;
    bit  mon_en = 1'b0;
    bit  first0 = 1'b1;
    bit  first1 = 1'b1;

    reset_sequencer u_dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .stage_ack  (ack),
        .rst_out    (ro),
        .busy       (busy),
        .done       (done),
        .timeout_err(terr)
    );

    reset_sequencer #(
        .N_STAGES   (1),
        .HOLD_CYCLES(1),
        .STAGE_GAP  (0),
        .ACK_TIMEOUT(4)
    ) u_dut1 (
        .clk        (clk),
        .rst        (rst1),
        .req        (req1),
        .stage_ack  (ack1),
        .rst_out    (ro1),
        .busy       (busy1),
        .done       (done1),
        .timeout_err(terr1)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit changed(input ev_t a, input ev_t b);
        return (a.ro !== b.ro) || (a.busy !== b.busy) || (a.done !== b.done) || (a.terr !== b.terr);
    endfunction

    task automatic compare(input string name, input ev_t a, input ev_t x);
        checks++;
        if (a.cyc !== x.cyc || a.ro !== x.ro || a.busy !== x.busy || a.done !== x.done || a.terr !== x.terr) begin
            failures++;
            $display("FAIL %s: got cyc=%0d rst_out=%b busy=%b done=%b terr=%b, expected cyc=%0d rst_out=%b busy=%b done=%b terr=%b",
                     name, a.cyc, a.ro, a.busy, a.done, a.terr, x.cyc, x.ro, x.busy, x.done, x.terr);
        end
    endtask

    // Monitor: every change of a DUT's outputs is one event, matched in order against its queue.
    always @(negedge clk) begin
        if (mon_en) begin
            a0 = '{cyc, ro, busy, done, terr};
            if (first0 || changed(a0, prev0)) begin
                if (q0.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dut0_unexpected: got cyc=%0d rst_out=%b busy=%b done=%b terr=%b, expected no event",
                             a0.cyc, a0.ro, a0.busy, a0.done, a0.terr);
                end else begin
                    compare("dut0_event", a0, q0.pop_front());
                end
            end
            prev0  = a0;
            first0 = 1'b0;

            a1 = '{cyc, {2'b00, ro1}, busy1, done1, terr1};
            if (first1 || changed(a1, prev1)) begin
                if (q1.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dut1_unexpected: got cyc=%0d rst_out=%b busy=%b done=%b terr=%b, expected no event",
                             a1.cyc, a1.ro, a1.busy, a1.done, a1.terr);
                end else begin
                    compare("dut1_event", a1, q1.pop_front());
                end
            end
            prev1  = a1;
            first1 = 1'b0;
        end
    end

    // Ack model: mode 0 acks from the 2nd cycle after release, 1 stuck high, 2 never.
    initial begin
        d = '{0, 0, 0};
        forever begin
            @(posedge clk);
            #2;
            for (int k = 0; k < 3; k++) begin
                d[k]   = ro[k] ? 0 : ((d[k] < 1000) ? d[k] + 1 : d[k]);
                ack[k] = (mode[k] == 1) ? 1'b1 : (mode[k] == 2) ? 1'b0 : (d[k] > 2);
            end
            d1      = ro1[0] ? 0 : ((d1 < 1000) ? d1 + 1 : d1);
            ack1[0] = (mode1 == 1) ? 1'b1 : (mode1 == 2) ? 1'b0 : (d1 > 2);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic e0(input int off, input logic [2:0] r, input logic b, input logic dn, input logic er);
        ev_t e;
        e = '{base + off, r, b, dn, er};
        q0.push_back(e);
    endtask

    task automatic e1(input int off, input logic r, input logic b, input logic dn, input logic er);
        ev_t e;
        e = '{base + off, {2'b00, r}, b, dn, er};
        q1.push_back(e);
    endtask

    initial begin
        mode = '{0, 0, 0};
        #1;
        rst  = 1'b1;
        rst1 = 1'b1;
        tick(5);

        // Power-up on both instances
        rst    = 1'b0;
        rst1   = 1'b0;
        base   = cyc;
        mon_en = 1'b1;
        e0(0,  3'b111, 1, 0, 0);
        e0(16, 3'b110, 1, 0, 0);
        e0(23, 3'b100, 1, 0, 0);
        e0(30, 3'b000, 1, 0, 0);
        e0(33, 3'b000, 1, 1, 0);
        e0(34, 3'b000, 0, 0, 0);
        e1(0, 1'b1, 1, 0, 0);
        e1(1, 1'b0, 1, 0, 0);
        e1(4, 1'b0, 1, 1, 0);
        e1(5, 1'b0, 0, 0, 0);
        tick(40);

        // Acks stuck high before release
        mode = '{1, 1, 1};
        base = cyc;
        req  = 1'b1;
        e0(1,  3'b111, 1, 0, 0);
        e0(17, 3'b110, 1, 0, 0);
        e0(22, 3'b100, 1, 0, 0);
        e0(27, 3'b000, 1, 0, 0);
        e0(28, 3'b000, 1, 1, 0);
        e0(29, 3'b000, 0, 0, 0);
        tick(1);
        req = 1'b0;
        tick(40);

        // Stage 1 never acks
        mode = '{0, 2, 0};
        base = cyc;
        req  = 1'b1;
        e0(1,  3'b111, 1, 0, 0);
        e0(17, 3'b110, 1, 0, 0);
        e0(24, 3'b100, 1, 0, 0);
        e0(88, 3'b100, 1, 0, 1);
        e0(92, 3'b000, 1, 0, 1);
        e0(95, 3'b000, 1, 1, 1);
        e0(96, 3'b000, 0, 0, 1);
        tick(1);
        req = 1'b0;
        tick(110);

        // New req clears timeout_err; req during GAP aborts and restarts
        mode = '{0, 0, 0};
        base = cyc;
        req  = 1'b1;
        e0(1,  3'b111, 1, 0, 0);
        e0(17, 3'b110, 1, 0, 0);
        e0(22, 3'b111, 1, 0, 0);
        e0(38, 3'b110, 1, 0, 0);
        e0(45, 3'b100, 1, 0, 0);
        e0(52, 3'b000, 1, 0, 0);
        e0(55, 3'b000, 1, 1, 0);
        e0(56, 3'b000, 0, 0, 0);
        tick(1);
        req = 1'b0;
        tick(20);
        req = 1'b1;
        tick(1);
        req = 1'b0;
        tick(60);

        // rst asserted while waiting on stage 2, after a timeout
        mode = '{0, 2, 2};
        base = cyc;
        req  = 1'b1;
        e0(1,   3'b111, 1, 0, 0);
        e0(17,  3'b110, 1, 0, 0);
        e0(24,  3'b100, 1, 0, 0);
        e0(88,  3'b100, 1, 0, 1);
        e0(92,  3'b000, 1, 0, 1);
        e0(95,  3'b111, 1, 0, 0);
        e0(113, 3'b110, 1, 0, 0);
        e0(120, 3'b100, 1, 0, 0);
        e0(127, 3'b000, 1, 0, 0);
        e0(130, 3'b000, 1, 1, 0);
        e0(131, 3'b000, 0, 0, 0);
        tick(1);
        req = 1'b0;
        tick(94);
        rst  = 1'b1;
        mode = '{0, 0, 0};
        tick(2);
        rst = 1'b0;
        tick(40);

        // Single-stage instance: timeout on the last stage, then immediate ack
        mode1 = 2;
        base  = cyc;
        req1  = 1'b1;
        e1(1, 1'b1, 1, 0, 0);
        e1(2, 1'b0, 1, 0, 0);
        e1(6, 1'b0, 1, 1, 1);
        e1(7, 1'b0, 0, 0, 1);
        tick(1);
        req1 = 1'b0;
        tick(10);
        mode1 = 1;
        base  = cyc;
        req1  = 1'b1;
        e1(1, 1'b1, 1, 0, 0);
        e1(2, 1'b0, 1, 0, 0);
        e1(3, 1'b0, 1, 1, 0);
        e1(4, 1'b0, 0, 0, 0);
        tick(1);
        req1 = 1'b0;
        tick(10);

        while (q0.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL dut0_missing: got no event, expected cyc=%0d rst_out=%b", q0[0].cyc, q0[0].ro);
            void'(q0.pop_front());
        end
        while (q1.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL dut1_missing: got no event, expected cyc=%0d rst_out=%b", q1[0].cyc, q1[0].ro);
            void'(q1.pop_front());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
